// File: rtl/mem_responder.sv
// Wait-state memory responder: WRAM + HRAM behind a three-state IDLE/WAIT/RESP handshake.
// Optional echo of WRAM at 0xE000-0xFDFF is enabled by defining ECHO_RAM_EN.
module mem_responder #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int DATA_W = 8;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {R_NONE, R_WRAM, R_HRAM} region_t;

  // Echo addresses differ from WRAM only in bit 13, so addr[12:0] indexes WRAM either way.
  function automatic region_t decode(input logic [15:0] a);
    if (a >= 16'hC000 && a <= 16'hDFFF) return R_WRAM;
`ifdef ECHO_RAM_EN
    if (a >= 16'hE000 && a <= 16'hFDFF) return R_WRAM;
`endif
    if (a >= 16'hFF80 && a <= 16'hFFFE) return R_HRAM;
    return R_NONE;
  endfunction

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                accept, enter_resp;

  logic [15:0]         addr_l;
  logic                we_l;
  logic [DATA_W-1:0]   wdata_l;

  logic [15:0]         acc_addr;
  logic                acc_we;
  logic [DATA_W-1:0]   acc_wdata;
  region_t             acc_rgn, rgn_l;

  logic [DATA_W-1:0]   wram [0:8191];
  logic [DATA_W-1:0]   hram [0:126];
  logic [DATA_W-1:0]   rd_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_l  <= addr;
      we_l    <= we;
      wdata_l <= wdata;
    end
  end

  // With zero wait cycles the access completes on the accepting edge, before the latch holds it.
  assign acc_addr  = (state == IDLE) ? addr  : addr_l;
  assign acc_we    = (state == IDLE) ? we    : we_l;
  assign acc_wdata = (state == IDLE) ? wdata : wdata_l;
  assign acc_rgn   = decode(acc_addr);
  assign rgn_l     = decode(addr_l);

  // Stage p0: storage access on the edge entering RESP
  always_ff @(posedge clk) begin
    if (enter_resp && !rst) begin
      if (acc_we) begin
        case (acc_rgn)
          R_WRAM:  wram[acc_addr[12:0]] <= acc_wdata;
          R_HRAM:  hram[acc_addr[6:0]]  <= acc_wdata;
          default: ;
        endcase
        rd_p0 <= 8'hFF;
      end else begin
        case (acc_rgn)
          R_WRAM:  rd_p0 <= wram[acc_addr[12:0]];
          R_HRAM:  rd_p0 <= hram[acc_addr[6:0]];
          default: rd_p0 <= 8'hFF;
        endcase
      end
    end
  end

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);
  assign err   = ready && (rgn_l == R_NONE);
  assign rdata = ready ? rd_p0 : 8'hFF;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with 3 wait cycles, one with 0.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req3 = 1'b0, req0 = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdata3, rdata0;
  logic        ready3, ready0, busy3, busy0, err3, err0;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata3), .ready(ready3), .busy(busy3), .err(err3)
  );

  mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One access; inputs are scrambled after acceptance so only latched values can matter.
  task automatic do_access(input bit sel0, input logic w, input logic [15:0] a,
                           input logic [7:0] d, output logic [7:0] rd, output logic er,
                           output int lat, output int bcnt);
    bit seen;
    @(negedge clk);
    we = w; addr = a; wdata = d;
    if (sel0) req0 = 1'b1; else req3 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0; req3 = 1'b0; we = ~w; addr = 16'h1234; wdata = ~d;
    lat = 0; bcnt = 0; seen = 1'b0; rd = 8'h00; er = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (sel0 ? busy0 : busy3) bcnt++;
      if (sel0 ? ready0 : ready3) begin
        seen = 1'b1;
        lat  = n;
        rd   = sel0 ? rdata0 : rdata3;
        er   = sel0 ? err0 : err3;
      end
    end
    check("ready_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("ready_one_cycle", 32'(sel0 ? ready0 : ready3), 32'd0);
    check("idle_rdata_ff",   32'(sel0 ? rdata0 : rdata3), 32'hFF);
    check("idle_busy_low",   32'(sel0 ? busy0 : busy3), 32'd0);
    check("idle_err_low",    32'(sel0 ? err0 : err3), 32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    logic       er;
    int         lat, bc, nrdy, k;
    int         t[3];

    #2;
    check("rst_ready3", 32'(ready3), 32'd0);
    check("rst_busy3",  32'(busy3),  32'd0);
    check("rst_err3",   32'(err3),   32'd0);
    check("rst_rdata3", 32'(rdata3), 32'hFF);
    check("rst_rdata0", 32'(rdata0), 32'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic write/read with latency and busy duration
    do_access(1'b0, 1'b1, 16'hC123, 8'hA5, rd, er, lat, bc);
    check("wr_latency", 32'(lat), 32'd4);
    check("wr_busy_cycles", 32'(bc), 32'd4);
    check("wr_err", 32'(er), 32'd0);
    do_access(1'b0, 1'b0, 16'hC123, 8'h00, rd, er, lat, bc);
    check("rd_C123", 32'(rd), 32'hA5);
    check("rd_C123_err", 32'(er), 32'd0);
    check("rd_latency", 32'(lat), 32'd4);

    // Unmapped accesses leave HRAM alone
    do_access(1'b0, 1'b1, 16'hFF80, 8'h42, rd, er, lat, bc);
    do_access(1'b0, 1'b0, 16'h8000, 8'h00, rd, er, lat, bc);
    check("rd_8000_data", 32'(rd), 32'hFF);
    check("rd_8000_err", 32'(er), 32'd1);
    do_access(1'b0, 1'b1, 16'h8000, 8'h3C, rd, er, lat, bc);
    check("wr_8000_err", 32'(er), 32'd1);
    do_access(1'b0, 1'b0, 16'hFF80, 8'h00, rd, er, lat, bc);
    check("rd_FF80_kept", 32'(rd), 32'h42);
    check("rd_FF80_err", 32'(er), 32'd0);

    // Echo region
    do_access(1'b0, 1'b1, 16'hC010, 8'h99, rd, er, lat, bc);
    do_access(1'b0, 1'b1, 16'hE010, 8'h5A, rd, er, lat, bc);
`ifdef ECHO_RAM_EN
    check("echo_wr_err", 32'(er), 32'd0);
    do_access(1'b0, 1'b0, 16'hC010, 8'h00, rd, er, lat, bc);
    check("echo_rd_C010", 32'(rd), 32'h5A);
`else
    check("echo_wr_err", 32'(er), 32'd1);
    do_access(1'b0, 1'b0, 16'hC010, 8'h00, rd, er, lat, bc);
    check("echo_rd_C010", 32'(rd), 32'h99);
`endif

    // Boundaries
    do_access(1'b0, 1'b1, 16'hDFFF, 8'h81, rd, er, lat, bc);
    do_access(1'b0, 1'b1, 16'hFFFE, 8'hE7, rd, er, lat, bc);
    do_access(1'b0, 1'b1, 16'hFF80, 8'h18, rd, er, lat, bc);
    do_access(1'b0, 1'b0, 16'hDFFF, 8'h00, rd, er, lat, bc);
    check("rd_DFFF", 32'(rd), 32'h81);
    do_access(1'b0, 1'b0, 16'hFFFE, 8'h00, rd, er, lat, bc);
    check("rd_FFFE", 32'(rd), 32'hE7);
    do_access(1'b0, 1'b0, 16'hFF80, 8'h00, rd, er, lat, bc);
    check("rd_FF80", 32'(rd), 32'h18);
    do_access(1'b0, 1'b0, 16'hFF7F, 8'h00, rd, er, lat, bc);
    check("rd_FF7F_err", 32'(er), 32'd1);
    check("rd_FF7F_data", 32'(rd), 32'hFF);
    do_access(1'b0, 1'b0, 16'hFFFF, 8'h00, rd, er, lat, bc);
    check("rd_FFFF_err", 32'(er), 32'd1);

    // Zero wait cycles
    do_access(1'b1, 1'b1, 16'hFFFE, 8'h6B, rd, er, lat, bc);
    check("w0_wr_latency", 32'(lat), 32'd1);
    do_access(1'b1, 1'b0, 16'hFFFE, 8'h00, rd, er, lat, bc);
    check("w0_rd_latency", 32'(lat), 32'd1);
    check("w0_rd_FFFE", 32'(rd), 32'h6B);
    check("w0_busy_cycles", 32'(bc), 32'd1);

    // Request held high: ready pulses every WAIT_CYCLES + 2 cycles
    @(negedge clk);
    req3 = 1'b1; we = 1'b0; addr = 16'hFFFE;
    k = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ready3) begin
        if (k < 3) t[k] = n;
        if (k == 0) check("held_rdata", 32'(rdata3), 32'hE7);
        k++;
      end
    end
    req3 = 1'b0;
    check("held_pulses", 32'(k), 32'd4);
    check("held_first", 32'(t[0]), 32'd4);
    check("held_gap1", 32'(t[1] - t[0]), 32'd5);
    check("held_gap2", 32'(t[2] - t[1]), 32'd5);
    for (int n = 0; n < 10 && busy3; n++) @(negedge clk);
    check("held_drained", 32'(busy3), 32'd0);

    // Reset during WAIT aborts the write
    do_access(1'b0, 1'b1, 16'hD000, 8'h11, rd, er, lat, bc);
    @(negedge clk);
    req3 = 1'b1; we = 1'b1; addr = 16'hD000; wdata = 8'h77;
    @(posedge clk); #1;
    req3 = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy3), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_busy_now", 32'(busy3), 32'd0);
    check("rst_ready_now", 32'(ready3), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nrdy = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ready3) nrdy++;
    end
    check("rst_no_ready", 32'(nrdy), 32'd0);
    do_access(1'b0, 1'b0, 16'hD000, 8'h00, rd, er, lat, bc);
    check("rst_D000_kept", 32'(rd), 32'h11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
